deserializer: RTL and testbench

- Receive-side counterpart of the team's 16-bit serializer.
- Samples a contiguous MSB-first serial burst qualified by a valid strobe and rebuilds the parallel word plus its bit count.
- Presents the result as a one-cycle-valid parallel word with a matching length field.
- Sits at the link sink and feeds parallel consumers; there is no backpressure.

---
 rtl/deserializer.sv | 123 ++++++++++++
 tb/tb_deserializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver: rebuilds a word of 1..DATA_W bits plus its length.
// Optional DESER_MIN_LEN_EN discards frames shorter than MIN_LEN and pulses drop_o instead.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = 5,
  parameter int MIN_LEN = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] data_o,
  output logic [MOD_W-1:0]  data_mod_o,
  output logic              data_val_o,
  output logic              busy_o,
  output logic              drop_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [DATA_W-1:0] TopBit  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [MOD_W-1:0]  FullCnt = MOD_W'(DATA_W);
  localparam logic [MOD_W-1:0]  OneCnt  = MOD_W'(1);

  if (MOD_W != $clog2(DATA_W + 1) || MIN_LEN < 1 || MIN_LEN > DATA_W) begin : g_param_err
    $error("deserializer: inconsistent DATA_W/MOD_W/MIN_LEN");
  end

  state_t              state_q, state_d;
  logic [MOD_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;
  logic                drop_q, drop_d;

  logic [DATA_W-1:0]   base_shift, ins_shift, close_shift;
  logic [MOD_W-1:0]    base_cnt, ins_cnt, close_cnt;
  logic                close;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    mod_d       = mod_q;
    val_d       = 1'b0;
    drop_d      = 1'b0;
    close       = 1'b0;
    close_shift = shift_q;
    close_cnt   = cnt_q;

    // A new frame starts from a cleared register, so OR-ing the bit in is enough.
    base_shift = (state_q == SHIFT) ? shift_q : '0;
    base_cnt   = (state_q == SHIFT) ? cnt_q   : '0;
    ins_shift  = base_shift | ((ser_data_i ? TopBit : '0) >> base_cnt);
    ins_cnt    = base_cnt + OneCnt;

    if (ser_data_val_i) begin
      shift_d = ins_shift;
      cnt_d   = ins_cnt;
      state_d = SHIFT;
      if (ins_cnt == FullCnt) begin
        close       = 1'b1;
        close_shift = ins_shift;
        close_cnt   = ins_cnt;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    end else if (state_q == SHIFT) begin
      close   = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end

    if (close) begin
`ifdef DESER_MIN_LEN_EN
      if (close_cnt < MOD_W'(MIN_LEN)) begin
        drop_d = 1'b1;
      end else begin
        data_d = close_shift;
        mod_d  = close_cnt;
        val_d  = 1'b1;
      end
`else
      data_d = close_shift;
      mod_d  = close_cnt;
      val_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = val_q;
  assign busy_o     = (state_q == SHIFT);
`ifdef DESER_MIN_LEN_EN
  assign drop_o     = drop_q;
`else
  assign drop_o     = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer; inputs change and outputs are sampled on the falling edge.
// Builds with or without DESER_MIN_LEN_EN (MIN_LEN = 3).
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int MOD_W  = 5;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] data_o;
  logic [MOD_W-1:0]  data_mod_o;
  logic              data_val_o;
  logic              busy_o;
  logic              drop_o;

  int total = 0;
  int bad   = 0;

  deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .MIN_LEN(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ser_data_i     (ser_data_i),
    .ser_data_val_i (ser_data_val_i),
    .data_o         (data_o),
    .data_mod_o     (data_mod_o),
    .data_val_o     (data_val_o),
    .busy_o         (busy_o),
    .drop_o         (drop_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then land on the following falling edge.
  task automatic step(input logic v, input logic d);
    ser_data_val_i = v;
    ser_data_i     = d;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_i = 1'b0; ser_data_val_i = 1'b0; ser_data_i = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({data_o, data_mod_o, data_val_o, busy_o, drop_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got data=%h mod=%0d val=%b busy=%b drop=%b want all 0",
               data_o, data_mod_o, data_val_o, busy_o, drop_o);
    end
    rst_i = 1'b1;
    step(1'b0, 1'b1);
    total++;
    if (data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got val=%b busy=%b want 0 0", data_val_o, busy_o);
    end
  endtask

  task automatic test_short_frame;
    logic [3:0] bits = 4'b1010;
    int busy_cnt = 0;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, bits[i]);
      if (busy_o === 1'b1) busy_cnt++;
      total++;
      if (data_val_o !== 1'b0) begin
        bad++; $display("FAIL short_early_val bit=%0d got val=%b want 0", 3 - i, data_val_o);
      end
    end
    step(1'b0, 1'b0);
    if (busy_o === 1'b1) busy_cnt++;
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'hA000 || data_mod_o !== 5'd4) begin
      bad++; $display("FAIL short_close got val=%b data=%h mod=%0d want 1 a000 4",
                      data_val_o, data_o, data_mod_o);
    end
    step(1'b0, 1'b1);
    if (busy_o === 1'b1) busy_cnt++;
    total++;
    if (busy_cnt !== 4) begin
      bad++; $display("FAIL short_busy_cycles got %0d want 4", busy_cnt);
    end
    total++;
    if (data_val_o !== 1'b0 || data_o !== 16'hA000 || data_mod_o !== 5'd4) begin
      bad++; $display("FAIL short_hold got val=%b data=%h mod=%0d want 0 a000 4",
                      data_val_o, data_o, data_mod_o);
    end
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    total++;
    if ({data_o, data_mod_o, data_val_o, busy_o, drop_o} !== '0) begin
      bad++;
      $display("FAIL midreset_async got data=%h mod=%0d val=%b busy=%b drop=%b want all 0",
               data_o, data_mod_o, data_val_o, busy_o, drop_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if (data_val_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 16'h0) begin
      bad++; $display("FAIL midreset_no_pulse got val=%b busy=%b data=%h want 0 0 0000",
                      data_val_o, busy_o, data_o);
    end
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'hB000 || data_mod_o !== 5'd4) begin
      bad++; $display("FAIL midreset_next_frame got val=%b data=%h mod=%0d want 1 b000 4",
                      data_val_o, data_o, data_mod_o);
    end
  endtask

  task automatic test_full_frame;
    logic [15:0] w = 16'hAAAA;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, w[i]);
      if (i == 1) begin
        total++;
        if (data_val_o !== 1'b0 || busy_o !== 1'b1) begin
          bad++; $display("FAIL full_bit15 got val=%b busy=%b want 0 1", data_val_o, busy_o);
        end
      end
    end
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'hAAAA || data_mod_o !== 5'd16 || busy_o !== 1'b0) begin
      bad++; $display("FAIL full_close got val=%b data=%h mod=%0d busy=%b want 1 aaaa 16 0",
                      data_val_o, data_o, data_mod_o, busy_o);
    end
    step(1'b0, 1'b0);
    total++;
    if (data_val_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL full_after got val=%b busy=%b want 0 0", data_val_o, busy_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] w = 16'h1234;
    for (int i = 15; i >= 0; i--) step(1'b1, w[i]);
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'h1234 || data_mod_o !== 5'd16) begin
      bad++; $display("FAIL b2b_first got val=%b data=%h mod=%0d want 1 1234 16",
                      data_val_o, data_o, data_mod_o);
    end
    step(1'b1, 1'b1);
    total++;
    if (data_val_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL b2b_restart got val=%b busy=%b want 0 1", data_val_o, busy_o);
    end
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'hE000 || data_mod_o !== 5'd3) begin
      bad++; $display("FAIL b2b_second got val=%b data=%h mod=%0d want 1 e000 3",
                      data_val_o, data_o, data_mod_o);
    end
  endtask

  task automatic test_val_gap;
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b1);
`ifdef DESER_MIN_LEN_EN
    total++;
    if (drop_o !== 1'b1 || data_val_o !== 1'b0 || data_o !== 16'hE000 || data_mod_o !== 5'd3) begin
      bad++; $display("FAIL gap_drop got drop=%b val=%b data=%h mod=%0d want 1 0 e000 3",
                      drop_o, data_val_o, data_o, data_mod_o);
    end
`else
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'hC000 || data_mod_o !== 5'd2 || drop_o !== 1'b0) begin
      bad++; $display("FAIL gap_first got val=%b data=%h mod=%0d drop=%b want 1 c000 2 0",
                      data_val_o, data_o, data_mod_o, drop_o);
    end
`endif
    step(1'b0, 1'b1);
    total++;
    if (data_val_o !== 1'b0 || drop_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL gap_idle got val=%b drop=%b busy=%b want 0 0 0",
                      data_val_o, drop_o, busy_o);
    end
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    total++;
    if (data_val_o !== 1'b1 || data_o !== 16'h5000 || data_mod_o !== 5'd4) begin
      bad++; $display("FAIL gap_second got val=%b data=%h mod=%0d want 1 5000 4",
                      data_val_o, data_o, data_mod_o);
    end
  endtask

  task automatic test_min_len;
    step(1'b1, 1'b1); step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`ifdef DESER_MIN_LEN_EN
    total++;
    if (drop_o !== 1'b1 || data_val_o !== 1'b0 || data_o !== 16'h5000 || data_mod_o !== 5'd4) begin
      bad++; $display("FAIL minlen_drop got drop=%b val=%b data=%h mod=%0d want 1 0 5000 4",
                      drop_o, data_val_o, data_o, data_mod_o);
    end
`else
    total++;
    if (drop_o !== 1'b0 || data_val_o !== 1'b1 || data_o !== 16'h8000 || data_mod_o !== 5'd2) begin
      bad++; $display("FAIL minlen_off got drop=%b val=%b data=%h mod=%0d want 0 1 8000 2",
                      drop_o, data_val_o, data_o, data_mod_o);
    end
`endif
    step(1'b0, 1'b0);
    total++;
    if (drop_o !== 1'b0 || data_val_o !== 1'b0) begin
      bad++; $display("FAIL minlen_one_cycle got drop=%b val=%b want 0 0", drop_o, data_val_o);
    end
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    total++;
    if (drop_o !== 1'b0 || data_val_o !== 1'b1 || data_o !== 16'hA000 || data_mod_o !== 5'd3) begin
      bad++; $display("FAIL minlen_exact got drop=%b val=%b data=%h mod=%0d want 0 1 a000 3",
                      drop_o, data_val_o, data_o, data_mod_o);
    end
  endtask

  initial begin
    test_reset;
    test_short_frame;
    test_reset_mid_frame;
    test_full_frame;
    test_back_to_back;
    test_val_gap;
    test_min_len;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
